// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports and the dmem side of the data-memory arbiter.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_gnt;
  logic              p0_rvalid;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_gnt;
  logic              p1_rvalid;
  logic [DATA_W-1:0] p1_rdata;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem_rd;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  mem_rd,
    output p0_gnt, p0_rvalid, p0_rdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output mem_we, mem_a, mem_wd
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata,
    input  p1_gnt, p1_rvalid, p1_rdata
  );

  modport mem (
    input  mem_we, mem_a, mem_wd,
    output mem_rd
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port dmem: round-robin on ties, burst-limited
// ownership, combinational grant and registered per-port read data.
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_t;

  owner_t            r_owner;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_last;
  logic              r_p0_rvalid;
  logic              r_p1_rvalid;
  logic [DATA_W-1:0] r_p0_rdata;
  logic [DATA_W-1:0] r_p1_rdata;

  owner_t            w_sel;
  logic              w_at_limit;
  logic [CNT_W-1:0]  w_cnt_inc;

  assign w_at_limit = (r_cnt >= MAX_CNT);
  assign w_cnt_inc  = w_at_limit ? MAX_CNT : r_cnt + CNT_W'(1);

  // The owner keeps the port unless it has used up its burst while the other waits.
  always_comb begin
    w_sel = OWN_NONE;
    case (r_owner)
      OWN_P0: begin
        if (bus.p0_req && !(w_at_limit && bus.p1_req)) w_sel = OWN_P0;
        else if (bus.p1_req)                            w_sel = OWN_P1;
      end
      OWN_P1: begin
        if (bus.p1_req && !(w_at_limit && bus.p0_req)) w_sel = OWN_P1;
        else if (bus.p0_req)                            w_sel = OWN_P0;
      end
      default: begin
        if (bus.p0_req && bus.p1_req) w_sel = r_last ? OWN_P0 : OWN_P1;
        else if (bus.p0_req)          w_sel = OWN_P0;
        else if (bus.p1_req)          w_sel = OWN_P1;
      end
    endcase
    if (!reset) w_sel = OWN_NONE;
  end

  always_comb begin
    bus.p0_gnt = (w_sel == OWN_P0);
    bus.p1_gnt = (w_sel == OWN_P1);
    bus.mem_we = 1'b0;
    bus.mem_a  = '0;
    bus.mem_wd = '0;
    case (w_sel)
      OWN_P0: begin
        bus.mem_we = bus.p0_we;
        bus.mem_a  = bus.p0_addr;
        bus.mem_wd = bus.p0_wdata;
      end
      OWN_P1: begin
        bus.mem_we = bus.p1_we;
        bus.mem_a  = bus.p1_addr;
        bus.mem_wd = bus.p1_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner     <= OWN_NONE;
      r_cnt       <= '0;
      r_last      <= 1'b1;
      r_p0_rvalid <= 1'b0;
      r_p1_rvalid <= 1'b0;
      r_p0_rdata  <= '0;
      r_p1_rdata  <= '0;
    end else begin
      r_p0_rvalid <= (w_sel == OWN_P0) && !bus.p0_we;
      r_p1_rvalid <= (w_sel == OWN_P1) && !bus.p1_we;
      if ((w_sel == OWN_P0) && !bus.p0_we) r_p0_rdata <= bus.mem_rd;
      if ((w_sel == OWN_P1) && !bus.p1_we) r_p1_rdata <= bus.mem_rd;
      if (w_sel != OWN_NONE) begin
        r_owner <= w_sel;
        r_last  <= (w_sel == OWN_P1);
        r_cnt   <= (w_sel == r_owner) ? w_cnt_inc : CNT_W'(1);
      end else begin
        r_owner <= OWN_NONE;
        r_cnt   <= '0;
      end
    end
  end

  assign bus.p0_rvalid = r_p0_rvalid;
  assign bus.p1_rvalid = r_p1_rvalid;
  assign bus.p0_rdata  = r_p0_rdata;
  assign bus.p1_rdata  = r_p1_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized
// run against a behavioural arbitration/memory model.
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic fill  = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // dmem stand-in: combinational read, write at the clock edge.
  logic [31:0] dmem    [256];
  logic [31:0] ref_mem [256];

  function automatic logic [31:0] seed_word(input int unsigned i);
    return (i * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 256; i++) dmem[i] <= seed_word(i);
    end else if (bus.mem_we) begin
      dmem[bus.mem_a[9:2]] <= bus.mem_wd;
    end
  end
  assign bus.mem_rd = dmem[bus.mem_a[9:2]];

  task automatic drive(input bit r0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                       input bit r1, input bit w1, input logic [31:0] a1, input logic [31:0] d1);
    bus.p0_req = r0; bus.p0_we = w0; bus.p0_addr = a0; bus.p0_wdata = d0;
    bus.p1_req = r1; bus.p1_we = w1; bus.p1_addr = a1; bus.p1_wdata = d1;
  endtask

  task automatic idle();
    drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    drive(1, 1, 32'h40, 32'h1111, 1, 0, 32'h80, 32'h0);
    #1;
    checks++; if (bus.p0_gnt !== 1'b0) begin failures++; $display("FAIL rst_p0_gnt got=%b exp=0", bus.p0_gnt); end
    checks++; if (bus.p1_gnt !== 1'b0) begin failures++; $display("FAIL rst_p1_gnt got=%b exp=0", bus.p1_gnt); end
    checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we got=%b exp=0", bus.mem_we); end
    checks++; if (bus.mem_a !== 32'h0) begin failures++; $display("FAIL rst_mem_a got=%h exp=0", bus.mem_a); end
    checks++; if (bus.mem_wd !== 32'h0) begin failures++; $display("FAIL rst_mem_wd got=%h exp=0", bus.mem_wd); end
    @(negedge clk);
    checks++; if (bus.p0_rvalid !== 1'b0 || bus.p1_rvalid !== 1'b0) begin
      failures++; $display("FAIL rst_rvalid got=%b%b exp=00", bus.p0_rvalid, bus.p1_rvalid); end
    checks++; if (bus.p0_rdata !== 32'h0 || bus.p1_rdata !== 32'h0) begin
      failures++; $display("FAIL rst_rdata got=%h/%h exp=0/0", bus.p0_rdata, bus.p1_rdata); end
    idle();
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_tie();
    drive(1, 0, 32'h10, 32'h0, 1, 0, 32'h20, 32'h0);
    #1;
    checks++; if (bus.p0_gnt !== 1'b1 || bus.p1_gnt !== 1'b0) begin
      failures++; $display("FAIL tie_c0_gnt got=%b%b exp=10", bus.p0_gnt, bus.p1_gnt); end
    checks++; if (bus.mem_a !== 32'h10 || bus.mem_we !== 1'b0) begin
      failures++; $display("FAIL tie_c0_mem got=%h/%b exp=10/0", bus.mem_a, bus.mem_we); end
    @(negedge clk);
    drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h20, 32'h0);
    #1;
    checks++; if (bus.p0_gnt !== 1'b0 || bus.p1_gnt !== 1'b1) begin
      failures++; $display("FAIL tie_c1_gnt got=%b%b exp=01", bus.p0_gnt, bus.p1_gnt); end
    checks++; if (bus.p0_rvalid !== 1'b1 || bus.p0_rdata !== ref_mem[4]) begin
      failures++; $display("FAIL tie_p0_read got=%b/%h exp=1/%h", bus.p0_rvalid, bus.p0_rdata, ref_mem[4]); end
    @(negedge clk);
    idle();
    #1;
    checks++; if (bus.p1_rvalid !== 1'b1 || bus.p1_rdata !== ref_mem[8] || bus.p0_rvalid !== 1'b0) begin
      failures++; $display("FAIL tie_p1_read got=%b/%h p0v=%b exp=1/%h p0v=0",
                           bus.p1_rvalid, bus.p1_rdata, bus.p0_rvalid, ref_mem[8]); end
    @(negedge clk);
  endtask

  task automatic test_burst();
    int k = 0;
    bit p0done = 0;
    logic [31:0] wd;
    bit eg0, eg1;
    for (int c = 0; c < 9; c++) begin
      wd = $urandom;
      drive(c >= 1 && !p0done, 0, 32'h200, 32'h0, k < 8, 1, 32'h100 + 32'(k * 4), wd);
      #1;
      eg0 = (c == 4);
      eg1 = (c != 4);
      checks++; if (bus.p0_gnt !== eg0 || bus.p1_gnt !== eg1) begin
        failures++; $display("FAIL burst_gnt c=%0d got=%b%b exp=%b%b", c, bus.p0_gnt, bus.p1_gnt, eg0, eg1); end
      if (c == 0) begin
        checks++; if (bus.mem_we !== 1'b1 || bus.mem_wd !== wd) begin
          failures++; $display("FAIL burst_wr got=%b/%h exp=1/%h", bus.mem_we, bus.mem_wd, wd); end
      end
      if (c == 5) begin
        checks++; if (bus.p0_rvalid !== 1'b1 || bus.p0_rdata !== ref_mem[128]) begin
          failures++; $display("FAIL burst_p0_read got=%b/%h exp=1/%h", bus.p0_rvalid, bus.p0_rdata, ref_mem[128]); end
      end
      if (eg1) begin ref_mem[64 + k] = wd; k++; end
      if (eg0) p0done = 1;
      @(negedge clk);
    end
    idle();
    @(negedge clk);
  endtask

  task automatic test_raw();
    drive(1, 1, 32'h40, 32'hDEADBEEF, 0, 0, 32'h0, 32'h0);
    #1;
    checks++; if (bus.p0_gnt !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_a !== 32'h40 || bus.mem_wd !== 32'hDEADBEEF) begin
      failures++; $display("FAIL raw_write got=%b/%b/%h/%h exp=1/1/40/deadbeef",
                           bus.p0_gnt, bus.mem_we, bus.mem_a, bus.mem_wd); end
    ref_mem[16] = 32'hDEADBEEF;
    @(negedge clk);
    drive(1, 0, 32'h40, 32'h0, 0, 0, 32'h0, 32'h0);
    #1;
    checks++; if (bus.p0_gnt !== 1'b1 || bus.p0_rvalid !== 1'b0) begin
      failures++; $display("FAIL raw_read_gnt got=%b rv=%b exp=1 rv=0", bus.p0_gnt, bus.p0_rvalid); end
    @(negedge clk);
    idle();
    #1;
    checks++; if (bus.p0_rvalid !== 1'b1 || bus.p0_rdata !== 32'hDEADBEEF) begin
      failures++; $display("FAIL raw_rdata got=%b/%h exp=1/deadbeef", bus.p0_rvalid, bus.p0_rdata); end
    @(negedge clk);
    checks++; if (bus.p0_rvalid !== 1'b0 || bus.p0_rdata !== 32'hDEADBEEF) begin
      failures++; $display("FAIL raw_hold got=%b/%h exp=0/deadbeef", bus.p0_rvalid, bus.p0_rdata); end
    @(negedge clk);
  endtask

  task automatic test_handover();
    int k = 0;
    bit late_done = 0;
    bit r0, eg0, eg1;
    logic [31:0] a0, wd;
    for (int c = 0; c < 9; c++) begin
      r0 = (c < 2) || (c >= 3 && !late_done);
      a0 = (c < 2) ? 32'(c * 4) : 32'h8;
      wd = $urandom;
      drive(r0, 0, a0, 32'h0, c >= 2 && k < 6, 1, 32'h300 + 32'(k * 4), wd);
      #1;
      eg0 = (c < 2) || (c == 6);
      eg1 = !eg0 && (c >= 2);
      checks++; if (bus.p0_gnt !== eg0 || bus.p1_gnt !== eg1) begin
        failures++; $display("FAIL hand_gnt c=%0d got=%b%b exp=%b%b", c, bus.p0_gnt, bus.p1_gnt, eg0, eg1); end
      if (c == 2) begin
        checks++; if (bus.mem_we !== 1'b1 || bus.mem_a !== 32'h300) begin
          failures++; $display("FAIL hand_mem got=%b/%h exp=1/300", bus.mem_we, bus.mem_a); end
      end
      if (eg1) begin ref_mem[192 + k] = wd; k++; end
      if (eg0 && c == 6) late_done = 1;
      @(negedge clk);
    end
    idle();
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 32'h40, 32'h0, 1, 1, 32'h44, 32'hCAFEF00D);
    #1;
    checks++; if (bus.p0_gnt !== 1'b1) begin failures++; $display("FAIL mid_pre_gnt got=%b exp=1", bus.p0_gnt); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (bus.p0_gnt !== 1'b0 || bus.p1_gnt !== 1'b0 || bus.mem_we !== 1'b0) begin
      failures++; $display("FAIL mid_gate got=%b%b we=%b exp=00 we=0", bus.p0_gnt, bus.p1_gnt, bus.mem_we); end
    @(posedge clk);
    #1;
    checks++; if (bus.p0_rvalid !== 1'b0 || bus.p0_rdata !== 32'h0 || bus.mem_we !== 1'b0) begin
      failures++; $display("FAIL mid_after_edge got=%b/%h we=%b exp=0/0 we=0", bus.p0_rvalid, bus.p0_rdata, bus.mem_we); end
    @(negedge clk);
    idle();
    reset = 1'b1;
    @(negedge clk);
    drive(1, 0, 32'h40, 32'h0, 1, 0, 32'h44, 32'h0);
    #1;
    checks++; if (bus.p0_gnt !== 1'b1 || bus.p1_gnt !== 1'b0) begin
      failures++; $display("FAIL mid_state_cleared got=%b%b exp=10", bus.p0_gnt, bus.p1_gnt); end
    @(negedge clk);
    drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h44, 32'h0);
    #1;
    checks++; if (bus.p0_rdata !== ref_mem[16] || bus.p1_gnt !== 1'b1) begin
      failures++; $display("FAIL mid_reread got=%h g1=%b exp=%h g1=1", bus.p0_rdata, bus.p1_gnt, ref_mem[16]); end
    @(negedge clk);
    idle();
    #1;
    checks++; if (bus.p1_rvalid !== 1'b1 || bus.p1_rdata !== ref_mem[17]) begin
      failures++; $display("FAIL mid_no_write got=%b/%h exp=1/%h", bus.p1_rvalid, bus.p1_rdata, ref_mem[17]); end
    reset = 1'b0;
    #1;
    checks++; if (bus.p1_rvalid !== 1'b0 || bus.p1_rdata !== 32'h0) begin
      failures++; $display("FAIL mid_rvalid_clear got=%b/%h exp=0/0", bus.p1_rvalid, bus.p1_rdata); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Model state: who held the port last cycle, how many grants in a row, who won last.
  int m_owner;
  int m_run;
  int m_last;

  function automatic int pick(input bit rq0, input bit rq1);
    bit rq[2];
    int other;
    rq[0] = rq0;
    rq[1] = rq1;
    if (m_owner < 0) begin
      if (rq0 && rq1) return 1 - m_last;
      if (rq0) return 0;
      if (rq1) return 1;
      return -1;
    end
    other = 1 - m_owner;
    if (rq[m_owner] && !(m_run >= MB && rq[other])) return m_owner;
    if (rq[other]) return other;
    return -1;
  endfunction

  task automatic test_random();
    bit          pend [2];
    bit          pwe  [2];
    logic [31:0] pa   [2];
    logic [31:0] pd   [2];
    bit          erv  [2];
    logic [31:0] erd  [2];
    bit          gg, gv;
    logic [31:0] gd;
    int          g, dens;
    logic [31:0] ea, ew;
    bit          ewe;

    idle();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    m_owner = -1; m_run = 0; m_last = 1;
    for (int p = 0; p < 2; p++) begin pend[p] = 0; pwe[p] = 0; pa[p] = '0; pd[p] = '0; erv[p] = 0; erd[p] = '0; end

    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < 2; p++) begin
        dens = (n >= 200 && p == 1) ? 2 : 6;
        if (!pend[p] && $urandom_range(0, 9) < dens) begin
          pend[p] = 1;
          pwe[p]  = 1'($urandom_range(0, 1));
          pa[p]   = 32'($urandom_range(0, 255)) << 2;
          pd[p]   = $urandom;
        end
      end
      drive(pend[0], pwe[0], pa[0], pd[0], pend[1], pwe[1], pa[1], pd[1]);
      #1;
      g   = pick(pend[0], pend[1]);
      ewe = (g >= 0) ? pwe[g] : 1'b0;
      ea  = (g >= 0) ? pa[g]  : 32'h0;
      ew  = (g >= 0) ? pd[g]  : 32'h0;
      checks++; if (bus.mem_we !== ewe || bus.mem_a !== ea || bus.mem_wd !== ew) begin
        failures++; $display("FAIL rnd_mem n=%0d got=%b/%h/%h exp=%b/%h/%h", n, bus.mem_we, bus.mem_a, bus.mem_wd, ewe, ea, ew); end
      for (int p = 0; p < 2; p++) begin
        gg = (p == 0) ? bus.p0_gnt    : bus.p1_gnt;
        gv = (p == 0) ? bus.p0_rvalid : bus.p1_rvalid;
        gd = (p == 0) ? bus.p0_rdata  : bus.p1_rdata;
        checks++; if (gg !== (g == p)) begin
          failures++; $display("FAIL rnd_gnt n=%0d p=%0d got=%b exp=%b", n, p, gg, (g == p)); end
        checks++; if (gv !== erv[p] || gd !== erd[p]) begin
          failures++; $display("FAIL rnd_read n=%0d p=%0d got=%b/%h exp=%b/%h", n, p, gv, gd, erv[p], erd[p]); end
      end
      erv[0] = 0;
      erv[1] = 0;
      if (g >= 0) begin
        if (pwe[g]) ref_mem[pa[g][9:2]] = pd[g];
        else begin erv[g] = 1; erd[g] = ref_mem[pa[g][9:2]]; end
        pend[g] = 0;
        m_run   = (g == m_owner) ? ((m_run + 1 > MB) ? MB : m_run + 1) : 1;
        m_owner = g;
        m_last  = g;
      end else begin
        m_owner = -1;
        m_run   = 0;
      end
      @(negedge clk);
    end
    idle();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = seed_word(i);
    idle();
    @(negedge clk);
    fill = 1'b0;
    test_reset();
    test_tie();
    test_burst();
    test_raw();
    test_handover();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
